// File: rtl/control_unit_pkg.sv
// Shared definitions for the instruction-sequencing control unit:
// opcodes, state encodings (also exposed on state_o), ALU selects and
// the instruction field positions.
package control_unit_pkg;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5
  } opcode_e;

  // Fixed encodings; state_o reports these values directly.
  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_e;

  localparam logic [2:0] ALU_PASS_A = 3'd0;
  localparam logic [2:0] ALU_ADD    = 3'd1;
  localparam logic [2:0] ALU_SUB    = 3'd2;

  // Instruction field positions.
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int DA_MSB  = 11;  // data-memory address (LOAD/STORE)
  localparam int DA_LSB  = 4;
  localparam int RA_MSB  = 11;  // ALU operand A
  localparam int RA_LSB  = 8;
  localparam int RB_MSB  = 7;   // ALU operand B
  localparam int RB_LSB  = 4;
  localparam int RD_MSB  = 3;   // destination / store source register
  localparam int RD_LSB  = 0;

endpackage

// File: rtl/control_unit.sv
// Moore control FSM for a small load/store datapath. Outputs are decoded
// from the registered state and the current instruction word only.
//
// state  | meaning
// -------+---------------------------------------------------------
// INIT   | reset / clear program counter
// FETCH  | load IR, advance PC
// DECODE | branch on opcode, no strobes
// NOOP   | idle execute cycle (also opcodes 6-15)
// LOAD_A | present memory address, wait for synchronous read
// LOAD_B | write memory data into register file
// STORE  | write register to memory
// ADD    | Rd = Ra + Rb
// SUB    | Rd = Ra - Rb
// HALT   | stop until reset
module control_unit
  import control_unit_pkg::*;
#(
  parameter int DADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        IR,
  output logic               PC_clr,
  output logic               PC_up,
  output logic               IR_ld,
  output logic [DADDR_W-1:0] D_addr,
  output logic               D_wr,
  output logic               RF_s,
  output logic [3:0]         RF_W_addr,
  output logic               RF_W_en,
  output logic [3:0]         RF_Ra_addr,
  output logic [3:0]         RF_Rb_addr,
  output logic [2:0]         ALU_s0,
  output logic [3:0]         state_o
);

  state_e state;
  state_e state_nx;

  logic [3:0]         op_field;
  logic [DADDR_W-1:0] mem_addr;

  assign op_field = IR[OP_MSB:OP_LSB];
  // The address field is 8 bits; widen or narrow to the configured bus.
  assign mem_addr = DADDR_W'(IR[DA_MSB:DA_LSB]);
  assign state_o  = state;

  // State register; reset forces INIT immediately, aborting any instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nx;
  end

  // Next-state logic; unknown encodings recover through INIT.
  always_comb begin
    state_nx = S_INIT;
    case (state)
      S_INIT:   state_nx = S_FETCH;
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin
        case (op_field)
          OP_NOOP:  state_nx = S_NOOP;
          OP_STORE: state_nx = S_STORE;
          OP_LOAD:  state_nx = S_LOAD_A;
          OP_ADD:   state_nx = S_ADD;
          OP_SUB:   state_nx = S_SUB;
          OP_HALT:  state_nx = S_HALT;
          default:  state_nx = S_NOOP;
        endcase
      end
      S_NOOP:   state_nx = S_FETCH;
      S_LOAD_A: state_nx = S_LOAD_B;
      S_LOAD_B: state_nx = S_FETCH;
      S_STORE:  state_nx = S_FETCH;
      S_ADD:    state_nx = S_FETCH;
      S_SUB:    state_nx = S_FETCH;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_INIT;
    endcase
  end

  // Output decode; everything defaults to 0 so each state only lists what it drives.
  always_comb begin
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    IR_ld      = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = 4'd0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = 4'd0;
    RF_Rb_addr = 4'd0;
    ALU_s0     = ALU_PASS_A;
    case (state)
      S_INIT: PC_clr = 1'b1;
      S_FETCH: begin
        IR_ld = 1'b1;
        PC_up = 1'b1;
      end
      S_LOAD_A: begin
        D_addr = mem_addr;
        RF_s   = 1'b1;
      end
      S_LOAD_B: begin
        D_addr    = mem_addr;
        RF_s      = 1'b1;
        RF_W_addr = IR[RD_MSB:RD_LSB];
        RF_W_en   = 1'b1;
      end
      S_STORE: begin
        D_addr     = mem_addr;
        RF_Ra_addr = IR[RD_MSB:RD_LSB];
        ALU_s0     = ALU_PASS_A;
        D_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = IR[RA_MSB:RA_LSB];
        RF_Rb_addr = IR[RB_MSB:RB_LSB];
        RF_W_addr  = IR[RD_MSB:RD_LSB];
        RF_s       = 1'b0;
        RF_W_en    = 1'b1;
        ALU_s0     = (state == S_ADD) ? ALU_ADD : ALU_SUB;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: table of instructions with hand-computed execute
// outputs and latencies, plus sequences for reset, async abort and HALT.
module tb_control_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] IR;
  logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, state_o;
  logic [2:0]  ALU_s0;

  int tests  = 0;
  int failed = 0;

  control_unit #(.DADDR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .IR         (IR),
    .PC_clr     (PC_clr),
    .PC_up      (PC_up),
    .IR_ld      (IR_ld),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .ALU_s0     (ALU_s0),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ir;
    logic [3:0]  exec_state;  // state of the last execute cycle
    int          lat;         // FETCH to FETCH cycles
    logic [7:0]  da;
    logic        dw;
    logic        rfs;
    logic [3:0]  wa;
    logic        we;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [2:0]  alu;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [31:0] pack(input logic pcc, input logic pcu, input logic irl,
                                       input logic [7:0] da, input logic dw, input logic rfs,
                                       input logic [3:0] wa, input logic we,
                                       input logic [3:0] ra, input logic [3:0] rb,
                                       input logic [2:0] alu);
    return {3'b000, pcc, pcu, irl, da, dw, rfs, wa, we, ra, rb, alu};
  endfunction

  function automatic logic [31:0] pack_now();
    return pack(PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
                RF_Ra_addr, RF_Rb_addr, ALU_s0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          cyc;
    bit          done;
    logic [31:0] prev_out;
    logic [3:0]  prev_state;
    IR = v.ir;
    check($sformatf("v%0d fetch outs", idx), pack_now(),
          pack(0, 1, 1, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0));
    cyc        = 0;
    done       = 1'b0;
    prev_out   = '0;
    prev_state = '0;
    while (!done && cyc < 10) begin
      prev_out   = pack_now();
      prev_state = state_o;
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check($sformatf("v%0d decode state", idx), state_o, 32'd2);
        check($sformatf("v%0d decode outs", idx), pack_now(), 32'd0);
      end
      if (state_o == 4'd4)
        check($sformatf("v%0d load_a outs", idx), pack_now(),
              pack(0, 0, 0, v.da, 0, 1, 4'h0, 0, 4'h0, 4'h0, 3'd0));
      if (RF_W_en && D_wr) check($sformatf("v%0d wen and wr together", idx), 32'd1, 32'd0);
      if (state_o == 4'd1) done = 1'b1;
    end
    check($sformatf("v%0d latency", idx), cyc, v.lat);
    check($sformatf("v%0d exec state", idx), prev_state, v.exec_state);
    check($sformatf("v%0d exec outs", idx), prev_out,
          pack(0, 0, 0, v.da, v.dw, v.rfs, v.wa, v.we, v.ra, v.rb, v.alu));
  endtask

  initial begin
    //            ir        exec lat  da     dw rfs wa     we ra     rb     alu
    vecs[0] = '{16'h2053, 4'd5, 4, 8'h05, 0, 1, 4'h3, 1, 4'h0, 4'h0, 3'd0}; // LOAD
    vecs[1] = '{16'h1A07, 4'd6, 3, 8'hA0, 1, 0, 4'h0, 0, 4'h7, 4'h0, 3'd0}; // STORE
    vecs[2] = '{16'h312F, 4'd7, 3, 8'h00, 0, 0, 4'hF, 1, 4'h1, 4'h2, 3'd1}; // ADD
    vecs[3] = '{16'h412F, 4'd8, 3, 8'h00, 0, 0, 4'hF, 1, 4'h1, 4'h2, 3'd2}; // SUB
    vecs[4] = '{16'hF000, 4'd3, 3, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0}; // NOOP (op 15)
    vecs[5] = '{16'h0ABC, 4'd3, 3, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0}; // NOOP
    vecs[6] = '{16'h6123, 4'd3, 3, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0}; // NOOP (op 6)
    vecs[7] = '{16'h3ABC, 4'd7, 3, 8'h00, 0, 0, 4'hC, 1, 4'hA, 4'hB, 3'd1}; // ADD
    vecs[8] = '{16'h2FF1, 4'd5, 4, 8'hFF, 0, 1, 4'h1, 1, 4'h0, 4'h0, 3'd0}; // LOAD
    vecs[9] = '{16'h1000, 4'd6, 3, 8'h00, 1, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0}; // STORE

    // Reset held two cycles, then release.
    IR    = 16'h0000;
    rst_n = 1'b0;
    #1;
    check("reset state", state_o, 32'd0);
    repeat (2) @(negedge clk);
    check("reset state held", state_o, 32'd0);
    check("reset outs", pack_now(), pack(1, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0));
    rst_n = 1'b1;
    @(negedge clk);
    check("first fetch state", state_o, 32'd1);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Asynchronous reset in the middle of LOAD_A must abort without a write.
    IR = 16'h2053;
    @(negedge clk);
    @(negedge clk);
    check("abort in load_a", state_o, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check("async reset state", state_o, 32'd0);
    check("async reset outs", pack_now(), pack(1, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort no wen", RF_W_en, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("fetch after abort", state_o, 32'd1);
    check("fetch after abort outs", pack_now(), pack(0, 1, 1, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0));

    // HALT holds for 20 cycles with every output quiet.
    IR = 16'h5000;
    @(negedge clk);
    check("halt decode", state_o, 32'd2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("halt state c%0d", i), state_o, 32'd9);
      check($sformatf("halt outs c%0d", i), pack_now(), 32'd0);
    end
    rst_n = 1'b0;
    #1;
    check("halt reset state", state_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("fetch after halt", state_o, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter DADDR_W, default 8, SHALL set the data-memory address width.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port rst_n, input, 1, SHALL be the asynchronous active-low reset.
REQ-004 Port IR, input, 16, SHALL be the current instruction word, with opcode in IR[15:12].
REQ-005 Port PC_clr, output, 1, SHALL clear the program counter.
REQ-006 Port PC_up, output, 1, SHALL increment the program counter.
REQ-007 Port IR_ld, output, 1, SHALL load the instruction register.
REQ-008 Port D_addr, output, DADDR_W, SHALL be the data-memory address.
REQ-009 Port D_wr, output, 1, SHALL be the data-memory write enable.
REQ-010 Port RF_s, output, 1, SHALL select RF write data: 1 = memory, 0 = ALU.
REQ-011 Port RF_W_addr, output, 4, SHALL be the register-file write address.
REQ-012 Port RF_W_en, output, 1, SHALL be the register-file write enable.
REQ-013 Port RF_Ra_addr, output, 4, SHALL be register-file read address A.
REQ-014 Port RF_Rb_addr, output, 4, SHALL be register-file read address B.
REQ-015 Port ALU_s0, output, 3, SHALL be the ALU operation select: 0 = pass A, 1 = add, 2 = subtract.
REQ-016 Port state_o, output, 4, SHALL expose the current state encoding for debug.

Function
REQ-017 The block SHALL be a Moore FSM; all outputs SHALL be decoded from the registered state and IR only.
REQ-018 Opcode map SHALL be: 0 = NOOP, 1 = STORE, 2 = LOAD, 3 = ADD, 4 = SUB, 5 = HALT; opcodes 6-15 SHALL execute as NOOP.
REQ-019 The states SHALL be INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB and HALT.
REQ-020 INIT SHALL assert PC_clr and then go to FETCH.
REQ-021 FETCH SHALL assert IR_ld and PC_up for exactly one cycle and then go to DECODE.
REQ-022 DECODE SHALL assert no strobes and SHALL branch on IR[15:12] to NOOP, STORE, LOAD_A, ADD, SUB or HALT.
REQ-023 NOOP SHALL return to FETCH.
REQ-024 LOAD_A SHALL drive D_addr = IR[11:4] with RF_s = 1 and RF_W_en = 0, then go to LOAD_B.
REQ-025 LOAD_B SHALL hold the LOAD_A values, drive RF_W_addr = IR[3:0] and RF_W_en = 1, then go to FETCH; a LOAD therefore takes 2 execute cycles to cover the synchronous memory read.
REQ-026 STORE SHALL drive D_addr = IR[11:4], RF_Ra_addr = IR[3:0], ALU_s0 = 0 and D_wr = 1, then go to FETCH.
REQ-027 ADD and SUB SHALL each, for one cycle, drive:
- RF_Ra_addr = IR[11:8], RF_Rb_addr = IR[7:4], RF_W_addr = IR[3:0]
- RF_s = 0, RF_W_en = 1
- ALU_s0 = 1 (ADD) or 2 (SUB)
and SHALL then go to FETCH.
REQ-028 HALT SHALL hold with all strobes at 0 until rst_n is asserted.
REQ-029 In every state, each strobe not explicitly asserted (PC_clr, PC_up, IR_ld, D_wr, RF_W_en) SHALL be 0.
REQ-030 In every state, each address not explicitly driven SHALL be 0.
REQ-031 No state SHALL assert RF_W_en and D_wr together.
REQ-032 Instruction latency from FETCH back to FETCH SHALL be:
- NOOP, STORE, ADD, SUB: 3 cycles
- LOAD: 4 cycles
REQ-033 Unreachable state encodings SHALL transition to INIT.

Reset
REQ-034 While rst_n = 0, the state SHALL be INIT immediately, independent of clk.
REQ-035 While in INIT, all outputs SHALL be 0 except PC_clr = 1.
REQ-036 Reset asserted mid-instruction, including between LOAD_A and LOAD_B, SHALL abort that instruction with no RF_W_en or D_wr pulse.
REQ-037 After rst_n deasserts, the first rising edge SHALL move the state from INIT to FETCH.

Structure
REQ-038 A shared package SHALL hold:
- the opcode enum
- the state enum (4-bit, with fixed encodings matching state_o)
- ALU_s0 constants
- instruction field bit positions
REQ-039 The block SHALL be a single module containing a state register and an output-decode block, with no sub-module.

Verification
REQ-040 Hold rst_n = 0 for 2 cycles, then release -> PC_clr = 1 during reset; the next cycle is FETCH with IR_ld = 1 and PC_up = 1.
REQ-041 IR = 16'h2053 (LOAD mem[5] to R3) -> the LOAD_B cycle shows D_addr = 8'h05, RF_s = 1, RF_W_en = 1, RF_W_addr = 3; FETCH follows 4 cycles after the prior FETCH.
REQ-042 IR = 16'h1A07 (STORE R7 to mem[A0]) -> a single cycle with D_wr = 1, D_addr = 8'hA0, RF_Ra_addr = 7, and RF_W_en = 0.
REQ-043 IR = 16'h312F then 16'h412F -> ADD and then SUB cycles with Ra = 1, Rb = 2, W_addr = 15, and ALU_s0 = 1 then 2.
REQ-044 IR = 16'h5000 -> the FSM stays in HALT for 20 cycles with all strobes 0; IR = 16'hF000 behaves as NOOP.
REQ-045 Drive rst_n low asynchronously mid-LOAD_A -> the state becomes INIT before the next clk edge, with no RF_W_en pulse.
